// File: rtl/stream_pkg.sv
// Shared definitions for the keep/last byte-stream blocks: FSM states and
// keep-mask <-> byte-count helpers (MSB-first keep, byte 0 = keep MSB).
package stream_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BODY = 2'd1,
        S_TAIL = 2'd2
    } state_e;

    // Widest beat the helpers handle; callers pass their real byte count.
    localparam int MAX_BYTES = 64;

    // Leading-ones count of an MSB-aligned keep mask of nbytes bits
    // (mask occupies bits [nbytes-1:0]).
    function automatic int keep_to_cnt(input logic [MAX_BYTES-1:0] keep,
                                       input int nbytes);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes) begin
                if (run && keep[nbytes-1-i]) begin
                    cnt = cnt + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

    // MSB-aligned mask with cnt ones, occupying bits [nbytes-1:0].
    function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int cnt,
                                                         input int nbytes);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < cnt && i < nbytes) begin
                k[nbytes-1-i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/stream_out_slice.sv
// Registered output stage: captures a beat whenever the register is free
// (empty or being drained) and holds it stable under backpressure.
module stream_out_slice #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_valid,
    input  logic [DATA_WD-1:0]      beat_data,
    input  logic [DATA_BYTE_WD-1:0] beat_keep,
    input  logic                    beat_last,
    input  logic                    ready_out,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    out_free
);

    logic                    valid_q;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic                    last_q;

    assign out_free  = !valid_q || ready_out;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

    // Load a new beat (or go empty, with zeroed fields) only when free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (out_free) begin
            valid_q <= beat_valid;
            data_q  <= beat_valid ? beat_data : '0;
            keep_q  <= beat_valid ? beat_keep : '0;
            last_q  <= beat_valid && beat_last;
        end
    end

endmodule

// File: rtl/stream_insert_header.sv
// Prepends a 1..W byte header to each keep/last packet and re-packs the
// payload behind it, emitting an extra tail beat when the residue overflows.
module stream_insert_header
    import stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);

    localparam int CNT_W = BYTE_CNT_WD + 1;
    localparam int SUM_W = BYTE_CNT_WD + 2;
    localparam logic [SUM_W-1:0] W_SUM = SUM_W'(DATA_BYTE_WD);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     hlen_q, hlen_d;        // header length H
    logic [DATA_WD-1:0]   residue_q, residue_d;  // left-aligned carry bytes
    logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;  // valid bytes in residue

    logic                    out_free;
    logic                    hdr_fire;
    logic                    pay_fire;
    logic [CNT_W-1:0]        hdr_len;
    logic [DATA_WD-1:0]      hdr_res;
    logic [DATA_WD-1:0]      data_mask;
    logic [DATA_WD-1:0]      data_m;
    logic [CNT_W-1:0]        last_cnt;
    logic [SUM_W-1:0]        hl_sum;
    logic                    fits;
    logic [2*DATA_WD-1:0]    packed_beat;
    logic [DATA_BYTE_WD-1:0] sum_keep;
    logic [DATA_BYTE_WD-1:0] res_keep;

    logic                    beat_valid;
    logic [DATA_WD-1:0]      beat_data;
    logic [DATA_BYTE_WD-1:0] beat_keep;
    logic                    beat_last;

    // Byte-wise data mask from keep, so bytes past the last valid one read 0.
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
            assign data_mask[gi*8 +: 8] = {8{keep_in[gi]}};
        end
    endgenerate
    assign data_m = data_in & data_mask;

    assign ready_insert = !rst && (state_q == S_HDR);
    assign ready_in     = !rst && (state_q == S_BODY) && out_free;
    assign hdr_fire     = valid_insert && ready_insert;
    assign pay_fire     = valid_in && ready_in;

    assign hdr_len  = CNT_W'(byte_insert_cnt) + CNT_W'(1);
    assign hdr_res  = data_insert << (8 * (DATA_BYTE_WD - int'(hdr_len)));
    assign last_cnt = CNT_W'(keep_to_cnt(MAX_BYTES'(keep_in), DATA_BYTE_WD));
    assign hl_sum   = SUM_W'(hlen_q) + SUM_W'(last_cnt);
    assign fits     = (hl_sum <= W_SUM);
    assign sum_keep = DATA_BYTE_WD'(cnt_to_keep(int'(hl_sum), DATA_BYTE_WD));
    assign res_keep = DATA_BYTE_WD'(cnt_to_keep(int'(res_cnt_q), DATA_BYTE_WD));

    // Residue followed by the payload placed H bytes in: upper half is the
    // outgoing beat, lower half is the next left-aligned residue.
    assign packed_beat = {residue_q, {DATA_WD{1'b0}}}
                       | ({data_m, {DATA_WD{1'b0}}} >> (8 * int'(hlen_q)));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HDR;
            hlen_q    <= '0;
            residue_q <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hlen_q    <= hlen_d;
            residue_q <= residue_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // Next-state and residue bookkeeping.
    always_comb begin
        state_d   = state_q;
        hlen_d    = hlen_q;
        residue_d = residue_q;
        res_cnt_d = res_cnt_q;
        case (state_q)
            S_HDR: begin
                if (hdr_fire) begin
                    hlen_d    = hdr_len;
                    residue_d = hdr_res;
                    res_cnt_d = hdr_len;
                    state_d   = S_BODY;
                end
            end
            S_BODY: begin
                if (pay_fire) begin
                    residue_d = packed_beat[DATA_WD-1:0];
                    if (last_in) begin
                        if (fits) begin
                            state_d = S_HDR;
                        end else begin
                            res_cnt_d = CNT_W'(hl_sum - W_SUM);
                            state_d   = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (out_free) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // Beat presented to the output register in each state.
    always_comb begin
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_keep  = '0;
        beat_last  = 1'b0;
        case (state_q)
            S_BODY: begin
                if (pay_fire) begin
                    beat_valid = 1'b1;
                    beat_data  = packed_beat[2*DATA_WD-1:DATA_WD];
                    if (last_in && fits) begin
                        beat_keep = sum_keep;
                        beat_last = 1'b1;
                    end else begin
                        beat_keep = '1;
                    end
                end
            end
            S_TAIL: begin
                if (out_free) begin
                    beat_valid = 1'b1;
                    beat_data  = residue_q;
                    beat_keep  = res_keep;
                    beat_last  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    stream_out_slice #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_keep  (beat_keep),
        .beat_last  (beat_last),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .keep_out   (keep_out),
        .last_out   (last_out),
        .out_free   (out_free)
    );

endmodule
